// File: rtl/matrix_pkg.sv
// Shared geometry and scan state encoding for the 6x6 glyph matrix driver.
package matrix_pkg;
  localparam int MATRIX_ROWS = 6;
  localparam int MATRIX_COLS = 6;
  localparam int IMG_W       = MATRIX_ROWS * MATRIX_COLS;
  localparam int ROW_W       = $clog2(MATRIX_ROWS);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  function automatic logic [MATRIX_ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
    return MATRIX_ROWS'(1) << r;
  endfunction
endpackage

// File: rtl/glyph_matrix_scan_timer.sv
// Phase counter that wraps to 0 after len cycles and flags its last cycle; tc is combinational, no backpressure.
module scan_timer #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);
  assign tc = (cnt == len - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/glyph_matrix_scan.sv
// Row-multiplexed 6x6 LED driver: one registered cycle from FSM state to pins, free-running (no backpressure).
// Optional MATRIX_PWM_EN adds a brightness input that gates columns by duty within each dwell.
module glyph_matrix_scan
  import matrix_pkg::*;
#(
  parameter int DWELL_CYCLES   = 16,
  parameter int BLANK_CYCLES   = 2,
  parameter int ROW_ACTIVE_LOW = 0,
  parameter int COL_ACTIVE_LOW = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IMG_W-1:0]       img,
`ifdef MATRIX_PWM_EN
  input  logic [3:0]             brightness,
`endif
  output logic [MATRIX_ROWS-1:0] row_sel,
  output logic [MATRIX_COLS-1:0] col_drv,
  output logic                   frame_start
);
  localparam int MAX_LEN = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  // At least 4 bits so the PWM compare can always look at cnt[3:0].
  localparam int CNT_W   = ($clog2(MAX_LEN + 1) < 4) ? 4 : $clog2(MAX_LEN + 1);
  localparam logic [MATRIX_ROWS-1:0] ROW_IDLE = (ROW_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [MATRIX_COLS-1:0] COL_IDLE = (COL_ACTIVE_LOW != 0) ? '1 : '0;

  scan_state_t            state;
  scan_state_t            state_nxt;
  logic [ROW_W-1:0]       row;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       len;
  logic                   tc;
  logic                   load;
  logic [IMG_W-1:0]       shadow;
  logic [MATRIX_ROWS-1:0] row_act;
  logic [MATRIX_COLS-1:0] col_act;
`ifdef MATRIX_PWM_EN
  logic [3:0]             brightness_q;
`endif

  assign len  = (state == BLANK) ? CNT_W'(BLANK_CYCLES) : CNT_W'(DWELL_CYCLES);
  assign load = (state == BLANK) && (row == '0) && (cnt == '0);

  scan_timer #(.CNT_W(CNT_W)) u_timer (
    .clk (clk),
    .rst (rst),
    .len (len),
    .cnt (cnt),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tc) begin
      state_nxt = (state == BLANK) ? DRIVE : BLANK;
    end
  end

  // Shadow capture happens only at the top of a frame, so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      row         <= '0;
      shadow      <= '0;
      frame_start <= 1'b0;
`ifdef MATRIX_PWM_EN
      brightness_q <= '0;
`endif
    end else begin
      frame_start <= load;
      if (load) begin
        shadow <= img;
`ifdef MATRIX_PWM_EN
        brightness_q <= brightness;
`endif
      end
      if (state == DRIVE && tc) begin
        row <= (row == ROW_W'(MATRIX_ROWS - 1)) ? '0 : row + ROW_W'(1);
      end
    end
  end

  always_comb begin
    row_act = '0;
    col_act = '0;
    if (state == DRIVE) begin
      row_act = row_onehot(row);
      for (int r = 0; r < MATRIX_ROWS; r++) begin
        if (row == ROW_W'(r)) begin
          col_act = shadow[r*MATRIX_COLS +: MATRIX_COLS];
        end
      end
`ifdef MATRIX_PWM_EN
      if (cnt[3:0] >= brightness_q) begin
        col_act = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_sel <= ROW_IDLE;
      col_drv <= COL_IDLE;
    end else begin
      row_sel <= row_act ^ ROW_IDLE;
      col_drv <= col_act ^ COL_IDLE;
    end
  end
endmodule

// File: tb/tb_glyph_matrix_scan.sv
// Bench for glyph_matrix_scan: table of glyphs plus scoreboard of per-row expectations pushed at each frame start.
module tb_glyph_matrix_scan;
  localparam int DWELL = 16;
  localparam int BLANK = 2;
  localparam int FRAME = 6 * (DWELL + BLANK);

  typedef struct {
    logic [35:0]      img;
    logic [5:0][5:0]  col;
  } vec_t;

  typedef struct packed {
    logic [5:0] row;
    logic [5:0] col;
    logic [4:0] on;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [35:0] img;
  logic [5:0]  row_sel, col_drv, row_sel_n, col_drv_n;
  logic        frame_start, frame_start_n;
`ifdef MATRIX_PWM_EN
  logic [3:0]  brightness;
`endif

  always #5 clk = ~clk;

  glyph_matrix_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK),
                      .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(0)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .img         (img),
`ifdef MATRIX_PWM_EN
    .brightness  (brightness),
`endif
    .row_sel     (row_sel),
    .col_drv     (col_drv),
    .frame_start (frame_start)
  );

  glyph_matrix_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK),
                      .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)) u_inv (
    .clk         (clk),
    .rst         (rst),
    .img         (img),
`ifdef MATRIX_PWM_EN
    .brightness  (brightness),
`endif
    .row_sel     (row_sel_n),
    .col_drv     (col_drv_n),
    .frame_start (frame_start_n)
  );

  int tests = 0;
  int fails = 0;
  int inv_err = 0;
  int cyc = 0;
  int last_fs = -1;
  int run_len = 0;
  int gap = 0;
  bit have_dwell = 1'b0;
  bit run_bad = 1'b0;
  logic [5:0] run_row, inv_row, inv_col, inv_row_exp, inv_col_exp;
  logic [5:0][5:0] cur_cols;
  exp_t cur;
  exp_t sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    exp_t e;
    logic [5:0] want;
    cyc++;
    if ($countones(row_sel) > 1) inv_err++;
    if (row_sel == '0 && col_drv != '0) inv_err++;
    if (row_sel_n != ~row_sel || col_drv_n != ~col_drv || frame_start_n != frame_start) inv_err++;
    if (rst) begin
      sb.delete();
      run_len = 0;
      have_dwell = 1'b0;
      last_fs = -1;
      gap = 0;
      return;
    end
    if (frame_start) begin
      if (row_sel != '0) inv_err++;
      if (last_fs >= 0) check("frame_period", 64'(cyc - last_fs), 64'(FRAME));
      last_fs = cyc;
      for (int r = 0; r < 6; r++) begin
        e.row = 6'b000001 << r;
        e.col = cur_cols[r];
`ifdef MATRIX_PWM_EN
        e.on = 5'(brightness);
`else
        e.on = 5'(DWELL);
`endif
        sb.push_back(e);
      end
    end
    if (row_sel != '0) begin
      if (run_len == 0) begin
        check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
        if (sb.size() != 0) cur = sb.pop_front();
        else cur = '0;
        if (have_dwell) check("blank_gap", 64'(gap), 64'(BLANK));
        else if (last_fs >= 0) check("first_row_delay", 64'(cyc - last_fs), 64'(BLANK));
        run_row = row_sel;
        run_bad = 1'b0;
        inv_row = row_sel_n;
        inv_col = col_drv_n;
        inv_row_exp = ~cur.row;
        inv_col_exp = (cur.on != 0) ? ~cur.col : 6'h3F;
      end
      want = (run_len < int'(cur.on)) ? cur.col : 6'h00;
      if (row_sel != run_row || col_drv != want) run_bad = 1'b1;
      run_len++;
    end else begin
      if (run_len > 0) begin
        check("row_sel", 64'(run_row), 64'(cur.row));
        check("col_drv_dwell_bad", 64'(run_bad), 64'(0));
        check("dwell_len", 64'(run_len), 64'(DWELL));
        check("row_sel_active_low", 64'(inv_row), 64'(inv_row_exp));
        check("col_drv_active_low", 64'(inv_col), 64'(inv_col_exp));
        have_dwell = 1'b1;
        gap = 0;
        run_len = 0;
      end
      gap++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("frame_start_after_reset", 64'(frame_start), 64'(1));
  endtask

  task automatic wait_row(input logic [5:0] r, input int limit, input string name);
    int n = 0;
    while (row_sel != r && n < limit) begin
      step();
      n++;
    end
    check(name, 64'(row_sel), 64'(r));
  endtask

  task automatic wait_fs(input int limit, input string name);
    int n = 0;
    do begin
      step();
      n++;
    end while (!frame_start && n < limit);
    check(name, 64'(frame_start), 64'(1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    // col is packed row 5 first, row 0 last.
    vecs[0].img = 36'h00000003F; vecs[0].col = {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h3F};
    vecs[1].img = 36'hFC0000000; vecs[1].col = {6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    vecs[2].img = 36'h123456789; vecs[2].col = {6'h04, 6'h23, 6'h11, 6'h16, 6'h1E, 6'h09};
    vecs[3].img = 36'h555555555; vecs[3].col = {6'h15, 6'h15, 6'h15, 6'h15, 6'h15, 6'h15};
    vecs[4].img = 36'hFFFFFFFFF; vecs[4].col = {6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};
    vecs[5].img = 36'h000000000; vecs[5].col = {6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    rst = 1'b1;
    img = '0;
    cur_cols = '0;
`ifdef MATRIX_PWM_EN
    brightness = 4'd15;
`endif
    repeat (3) step();
    check("reset_row_sel", 64'(row_sel), 64'(6'h00));
    check("reset_col_drv", 64'(col_drv), 64'(6'h00));
    check("reset_frame_start", 64'(frame_start), 64'(0));
    check("reset_row_sel_active_low", 64'(row_sel_n), 64'(6'h3F));
    check("reset_col_drv_active_low", 64'(col_drv_n), 64'(6'h3F));

    for (int i = 0; i < 6; i++) begin
      img = vecs[i].img;
      cur_cols = vecs[i].col;
      pulse_reset();
      repeat (FRAME + 22) step();
    end

    // Free run over several frames.
    img = vecs[2].img;
    cur_cols = vecs[2].col;
    pulse_reset();
    repeat (3 * FRAME + 20) step();

    // Mid-frame image change must not disturb the frame in progress.
    img = vecs[0].img;
    cur_cols = vecs[0].col;
    pulse_reset();
    repeat (50) step();
    img = vecs[1].img;
    cur_cols = vecs[1].col;
    wait_fs(2 * FRAME, "midframe_next_frame_start");
    wait_row(6'b100000, 2 * FRAME, "midframe_reach_row5");
    check("midframe_row5_col", 64'(col_drv), 64'(6'h3F));
    repeat (40) step();

    // Reset during row 3 drive.
    wait_row(6'b001000, 2 * FRAME, "reach_row3");
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrow_rst_row_sel", 64'(row_sel), 64'(6'h00));
    check("midrow_rst_col_drv", 64'(col_drv), 64'(6'h00));
    check("midrow_rst_row_sel_active_low", 64'(row_sel_n), 64'(6'h3F));
    step();
    rst = 1'b0;
    step();
    check("midrow_restart_frame_start", 64'(frame_start), 64'(1));
    wait_row(6'b000001, 10, "midrow_restart_row0");
    repeat (FRAME) step();

`ifdef MATRIX_PWM_EN
    img = vecs[4].img;
    cur_cols = vecs[4].col;
    brightness = 4'd4;
    pulse_reset();
    repeat (FRAME + 22) step();
    brightness = 4'd0;
    pulse_reset();
    repeat (FRAME + 22) step();
`endif

    check("per_cycle_invariants", 64'(inv_err), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
